// File: rtl/hp_vpu_pkg.sv
// Shared types and constants for the vector unit front end.
// Instruction queue entry layout and default sizing live here.
package hp_vpu_pkg;

  localparam int IQ_DEPTH = 8;
  localparam int IQ_SEQ_W = 8;
  localparam int IQ_XLEN  = 32;

  typedef struct packed {
    logic [31:0]         instr;
    logic [IQ_XLEN-1:0]  rs1;
    logic [IQ_XLEN-1:0]  rs2;
    logic [IQ_SEQ_W-1:0] seq;
  } iq_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/hp_vpu_iq_ram.sv
// Instruction queue storage: one sync write port, one async read port.
// No reset on the array so it maps onto distributed RAM.
module hp_vpu_iq_ram
  import hp_vpu_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  iq_entry_t     wdata_i,
  input  logic [AW-1:0] raddr_i,
  output iq_entry_t     rdata_o
);

  iq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/hp_vpu_iq.sv
// Vector instruction queue between the offload port and D2 decode.
// First-word fall-through FIFO with stall hold and flush-to-empty.
module hp_vpu_iq
  import hp_vpu_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH,
  parameter int XLEN      = IQ_XLEN,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     x_valid_i,
  output logic                     x_ready_o,
  input  logic [31:0]              x_instr_i,
  input  logic [XLEN-1:0]          x_rs1_i,
  input  logic [XLEN-1:0]          x_rs2_i,
  output logic                     iq_valid_o,
  output logic [31:0]              iq_instr_o,
  output logic [XLEN-1:0]          iq_rs1_o,
  output logic [XLEN-1:0]          iq_rs2_o,
  output logic [IQ_SEQ_W-1:0]      iq_seq_o,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [IQ_SEQ_W-1:0] seq_q, seq_d;

  logic      full, empty;
  logic      enq, deq;
  iq_entry_t wdata, rdata;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Ready depends only on state and flush, never on stall.
  assign x_ready_o = !full && !flush_i;
  assign enq       = x_valid_i && x_ready_o;
  assign deq       = !empty && !stall_i;

  always_comb begin
    wdata       = '0;
    wdata.instr = x_instr_i;
    wdata.rs1   = x_rs1_i;
    wdata.rs2   = x_rs2_i;
    wdata.seq   = seq_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    seq_d    = seq_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        seq_d    = seq_q + IQ_SEQ_W'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
    end
  end

  hp_vpu_iq_ram #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .we_i    (enq),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign iq_valid_o    = !empty;
  assign iq_instr_o    = rdata.instr;
  assign iq_rs1_o      = rdata.rs1;
  assign iq_rs2_o      = rdata.rs2;
  assign iq_seq_o      = rdata.seq;
  assign count_o       = count_q;
  assign full_o        = full;
  assign empty_o       = empty;
  assign almost_full_o = (count_q >= AF_C);

endmodule

// File: tb/tb_hp_vpu_iq.sv
// Randomized and directed bench for hp_vpu_iq against a queue model.
// Model keeps entries in a SystemVerilog queue and a software seq counter.
module tb_hp_vpu_iq;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int AF    = DEPTH - 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_valid_i;
  logic        x_ready_o;
  logic [31:0] x_instr_i;
  logic [31:0] x_rs1_i;
  logic [31:0] x_rs2_i;
  logic        iq_valid_o;
  logic [31:0] iq_instr_o;
  logic [31:0] iq_rs1_o;
  logic [31:0] iq_rs2_o;
  logic [7:0]  iq_seq_o;
  logic        stall_i;
  logic        flush_i;
  logic [3:0]  count_o;
  logic        full_o;
  logic        empty_o;
  logic        almost_full_o;

  hp_vpu_iq #(
    .DEPTH     (DEPTH),
    .XLEN      (XLEN),
    .AF_THRESH (AF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .x_valid_i     (x_valid_i),
    .x_ready_o     (x_ready_o),
    .x_instr_i     (x_instr_i),
    .x_rs1_i       (x_rs1_i),
    .x_rs2_i       (x_rs2_i),
    .iq_valid_o    (iq_valid_o),
    .iq_instr_o    (iq_instr_o),
    .iq_rs1_o      (iq_rs1_o),
    .iq_rs2_o      (iq_rs2_o),
    .iq_seq_o      (iq_seq_o),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .almost_full_o (almost_full_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          seq;
  } ent_t;

  ent_t mq[$];
  int   mseq;
  int   n_chk;
  int   n_pass;
  int   n_cnt;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
  endtask

  task automatic check_outs();
    int n;
    n = mq.size();
    check("ready", 64'(x_ready_o), 64'((n < DEPTH) && !flush_i));
    check("valid", 64'(iq_valid_o), 64'(n != 0));
    check("count", 64'(count_o), 64'(n));
    check("full", 64'(full_o), 64'(n == DEPTH));
    check("empty", 64'(empty_o), 64'(n == 0));
    check("afull", 64'(almost_full_o), 64'(n >= AF));
    if (n != 0) begin
      check("instr", 64'(iq_instr_o), 64'(mq[0].instr));
      check("rs1", 64'(iq_rs1_o), 64'(mq[0].rs1));
      check("rs2", 64'(iq_rs2_o), 64'(mq[0].rs2));
      check("seq", 64'(iq_seq_o), 64'(mq[0].seq));
    end
  endtask

  // One clock: drive, check mid-cycle, advance model at the edge.
  task automatic cyc(input logic v, input logic [31:0] ins,
                     input logic st, input logic fl);
    bit   do_enq, do_deq;
    ent_t e;
    x_valid_i = v;
    x_instr_i = ins;
    x_rs1_i   = $urandom;
    x_rs2_i   = $urandom;
    stall_i   = st;
    flush_i   = fl;
    @(negedge clk);
    check_outs();
    if (fl) begin
      mq.delete();
    end else begin
      do_enq = v && (mq.size() < DEPTH);
      do_deq = (mq.size() != 0) && !st;
      if (do_deq) void'(mq.pop_front());
      if (do_enq) begin
        e.instr = ins;
        e.rs1   = x_rs1_i;
        e.rs2   = x_rs2_i;
        e.seq   = mseq;
        mq.push_back(e);
        mseq = (mseq + 1) % 256;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset();
    x_valid_i = 1'b0;
    stall_i   = 1'b1;
    flush_i   = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    mseq = 0;
    check("rst_valid", 64'(iq_valid_o), 64'(0));
    check("rst_count", 64'(count_o), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    mseq      = 0;
    rst_n     = 1'b0;
    x_valid_i = 1'b0;
    x_instr_i = '0;
    x_rs1_i   = '0;
    x_rs2_i   = '0;
    stall_i   = 1'b0;
    flush_i   = 1'b0;
    #12;
    check_outs();
    check("rst_ready", 64'(x_ready_o), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 1; i <= 3; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("drain_cnt", 64'(count_o), 64'(0));

    for (int i = 1; i <= 10; i++) cyc(1'b1, 32'(16 + i), 1'b1, 1'b0);
    check("full_hold", 64'(full_o), 64'(1));
    cyc(1'b1, 32'h99, 1'b0, 1'b0);
    check("full_deq", 64'(count_o), 64'(7));
    cyc(1'b1, 32'h9a, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) cyc(1'b1, 32'(256 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'(512 + i), 1'b1, 1'b0);
    n_cnt = mseq;
    cyc(1'b1, 32'h777, 1'b1, 1'b1);
    check("flush_empty", 64'(empty_o), 64'(1));
    cyc(1'b1, 32'h778, 1'b1, 1'b0);
    check("seq_keep", 64'(iq_seq_o), 64'(n_cnt));
    cyc(1'b0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(1024 + i), 1'b1, 1'b0);
    mid_reset();
    cyc(1'b1, 32'h4242, 1'b0, 1'b0);
    check("post_rst_seq", 64'(iq_seq_o), 64'(0));

    for (int i = 0; i < 600; i++)
      cyc(($urandom % 4) != 0, $urandom, ($urandom % 3) == 0,
          ($urandom % 25) == 0);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 5; j++) cyc(1'b1, $urandom, 1'b0, 1'b0);
      mid_reset();
    end
    for (int i = 0; i < 300; i++)
      cyc(($urandom % 2) != 0, $urandom, ($urandom % 2) == 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
